mem_ctrl: RTL and testbench

KS10 bus memory controller, directly downstream of the bus arbiter: it consumes the arbiter's memory request, address and data, and returns the memory acknowledge and read data.
- Decodes the cycle flags carried in the 36-bit bus address word.
- Drives a single-port synchronous SRAM through a programmable wait-state sequencer.
- Returns a one-cycle acknowledge aligned with read data.
- Signals non-existent memory (NXM) for out-of-range addresses.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the KS10 bus memory controller: cycle-flag bit positions,
// physical-address slice bounds, FSM state encoding and the bus cycle decoder.
package mem_pkg;

  localparam int FLAG_READ  = 3;
  localparam int FLAG_WRITE = 5;
  localparam int FLAG_IO    = 6;
  localparam int PA_LO      = 16;
  localparam int PA_HI      = 35;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACK    = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  typedef struct packed {
    logic read;
    logic write;
    logic io;
    logic owned;
  } cycle_t;

  // Read+write together is the read half of read-pause-write, so write is masked by read.
  function automatic cycle_t decode(input logic req, input logic [0:35] addr);
    cycle_t c;
    c.io    = addr[FLAG_IO];
    c.read  = addr[FLAG_READ];
    c.write = addr[FLAG_WRITE] & ~addr[FLAG_READ];
    c.owned = req & ~addr[FLAG_IO] & (addr[FLAG_READ] | addr[FLAG_WRITE]);
    return c;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// KS10 bus memory controller: decodes arbiter memory cycles, sequences a synchronous
// SRAM through programmable wait states, returns a one-cycle ack or an NXM pulse.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int MEM_WORDS   = 262144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busREQI,
  output logic        busACKO,
  input  logic [0:35] busADDRI,
  input  logic [0:35] busDATAI,
  output logic [0:35] busDATAO,
  output logic [0:19] ssramADDR,
  output logic [0:35] ssramDOUT,
  input  logic [0:35] ssramDIN,
  output logic        ssramRD,
  output logic        ssramWR,
  output logic        nxmO
);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        op_read;
  logic        rd_pending;
  logic [0:35] rd_data;
  logic        ack;
  logic [0:19] addr_q;
  logic [0:35] dout_q;
  logic        rd_q;
  logic        wr_q;
  logic        nxm_q;

  cycle_t      cyc;
  logic [0:19] pa;
  logic        in_range;

  assign cyc      = decode(busREQI, busADDRI);
  assign pa       = busADDRI[PA_LO:PA_HI];
  assign in_range = ({1'b0, pa} < 21'(MEM_WORDS));

  assign busACKO   = ack;
  assign ssramADDR = addr_q;
  assign ssramDOUT = dout_q;
  assign ssramRD   = rd_q;
  assign ssramWR   = wr_q;
  assign nxmO      = nxm_q;

  // With zero wait states the SRAM word only appears during ACK, so it bypasses the capture register.
  assign busDATAO = (ack && op_read) ? ((WAIT_STATES == 0) ? ssramDIN : rd_data) : 36'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= 4'd0;
      op_read    <= 1'b0;
      rd_pending <= 1'b0;
      rd_data    <= 36'd0;
      ack        <= 1'b0;
      addr_q     <= 20'd0;
      dout_q     <= 36'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      nxm_q      <= 1'b0;
    end else begin
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      nxm_q      <= 1'b0;
      ack        <= 1'b0;
      rd_pending <= rd_q;
      if (rd_pending) begin
        rd_data <= ssramDIN;
      end else begin
        rd_data <= rd_data;
      end
      case (state)
        ST_IDLE: begin
          if (cyc.owned && in_range) begin
            addr_q  <= pa;
            dout_q  <= busDATAI;
            op_read <= cyc.read;
            rd_q    <= cyc.read;
            wr_q    <= cyc.write;
            state   <= ST_ACCESS;
          end else if (cyc.owned) begin
            nxm_q <= 1'b1;
            state <= ST_HOLD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (!busREQI) begin
            state <= ST_IDLE;
          end else if (WAIT_STATES == 0) begin
            ack   <= 1'b1;
            state <= ST_ACK;
          end else begin
            wait_cnt <= 4'(WAIT_STATES);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!busREQI) begin
            wait_cnt <= 4'd0;
            state    <= ST_IDLE;
          end else if (wait_cnt == 4'd1) begin
            wait_cnt <= 4'd0;
            ack      <= 1'b1;
            state    <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACK: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!busREQI) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_HOLD;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: transaction-level model predicts per-cycle outputs,
// a behavioural SRAM serves the strobes, directed literals pin the model.
module tb_mem_ctrl;

  localparam int WS = 2;
  localparam int MW = 262144;
  localparam int N  = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busREQI = 1'b0;
  logic        busACKO;
  logic [0:35] busADDRI = 36'd0;
  logic [0:35] busDATAI = 36'd0;
  logic [0:35] busDATAO;
  logic [0:19] ssramADDR;
  logic [0:35] ssramDOUT;
  logic [0:35] ssramDIN = 36'd0;
  logic        ssramRD;
  logic        ssramWR;
  logic        nxmO;

  mem_ctrl #(.WAIT_STATES(WS), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .busREQI(busREQI), .busACKO(busACKO),
    .busADDRI(busADDRI), .busDATAI(busDATAI), .busDATAO(busDATAO),
    .ssramADDR(ssramADDR), .ssramDOUT(ssramDOUT), .ssramDIN(ssramDIN),
    .ssramRD(ssramRD), .ssramWR(ssramWR), .nxmO(nxmO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment SRAM, kept separate from the reference memory below.
  logic [35:0] sram [int];
  always @(posedge clk) begin
    if (ssramWR) sram[int'(ssramADDR)] = ssramDOUT;
    if (ssramRD) ssramDIN <= sram.exists(int'(ssramADDR)) ? sram[int'(ssramADDR)] : 36'd0;
  end

  logic [35:0] ref_mem [int];
  bit          exp_ack [N];
  bit          exp_rd  [N];
  bit          exp_wr  [N];
  bit          exp_nxm [N];
  bit          exp_av  [N];
  bit          exp_dv  [N];
  logic [35:0] exp_data[N];
  logic [19:0] exp_addr[N];
  logic [35:0] exp_dout[N];
  bit          obs_ack [N];
  bit          obs_rd  [N];
  bit          obs_wr  [N];
  bit          obs_nxm [N];
  logic [35:0] obs_data[N];
  logic [19:0] obs_addr[N];

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input int c, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, c, act, exp);
    end
  endtask

  function automatic logic [35:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 36'd0;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      exp_ack[i] = 1'b0; exp_rd[i] = 1'b0; exp_wr[i] = 1'b0; exp_nxm[i] = 1'b0;
      exp_av[i] = 1'b0; exp_dv[i] = 1'b0; exp_data[i] = 36'd0;
      exp_addr[i] = 20'd0; exp_dout[i] = 36'd0;
    end
  end

  // Compare process: every cycle after reset, all outputs against the model.
  always @(negedge clk) begin
    if (mon_en && cyc < N) begin
      obs_ack[cyc] = busACKO; obs_rd[cyc] = ssramRD; obs_wr[cyc] = ssramWR;
      obs_nxm[cyc] = nxmO; obs_data[cyc] = busDATAO; obs_addr[cyc] = ssramADDR;
      chk("ack",  cyc, {35'd0, busACKO}, {35'd0, exp_ack[cyc]});
      chk("data", cyc, busDATAO, exp_data[cyc]);
      chk("rd",   cyc, {35'd0, ssramRD}, {35'd0, exp_rd[cyc]});
      chk("wr",   cyc, {35'd0, ssramWR}, {35'd0, exp_wr[cyc]});
      chk("nxm",  cyc, {35'd0, nxmO}, {35'd0, exp_nxm[cyc]});
      if (exp_av[cyc]) chk("addr", cyc, {16'd0, ssramADDR}, {16'd0, exp_addr[cyc]});
      if (exp_dv[cyc]) chk("dout", cyc, ssramDOUT, exp_dout[cyc]);
    end
  end

  // Predict the whole transaction from the request start cycle and the timing rules.
  task automatic sched(input bit rd, input bit wr, input bit io, input logic [19:0] pa,
                       input logic [35:0] wd, input int hold, input int gap,
                       output int t0, output int nxt);
    bit ours, inr, acked;
    int ta;
    logic [0:35] a;
    logic [8:0] junk;
    t0 = cyc;
    ours = (rd || wr) && !io;
    inr = int'(pa) < MW;
    ta = t0 + 2 + WS;
    acked = ours && inr && (hold >= 2 + WS);
    if (ours && !inr) exp_nxm[t0+1] = 1'b1;
    if (ours && inr) begin
      exp_rd[t0+1] = rd;
      exp_wr[t0+1] = wr && !rd;
      for (int c = t0 + 1; c <= (acked ? ta : t0 + 1); c++) begin
        exp_av[c] = 1'b1;
        exp_addr[c] = pa;
      end
      if (wr && !rd) begin
        exp_dv[t0+1] = 1'b1;
        exp_dout[t0+1] = wd;
        ref_mem[int'(pa)] = wd;
      end
      if (acked) begin
        exp_ack[ta] = 1'b1;
        if (rd) exp_data[ta] = ref_rd(int'(pa));
      end
    end
    nxt = t0 + hold + gap;
    if (acked && nxt < ta + 2) nxt = ta + 2;
    junk = 9'($urandom_range(0, 511));
    a = 36'd0;
    a[3] = rd; a[5] = wr; a[6] = io;
    a[7:15] = junk;
    a[16:35] = pa;
    busADDRI = a;
    busDATAI = wd;
  endtask

  task automatic run(input int t0, input int hold, input int nxt);
    for (int c = t0; c < nxt; c++) begin
      busREQI = (c < t0 + hold);
      @(posedge clk); #1;
    end
    busREQI = 1'b0;
  endtask

  task automatic txn(input bit rd, input bit wr, input bit io, input logic [19:0] pa,
                     input logic [35:0] wd, input int hold, input int gap, output int t0);
    int nxt;
    sched(rd, wr, io, pa, wd, hold, gap, t0, nxt);
    run(t0, hold, nxt);
  endtask

  initial begin
    int t0, nxt, n;
    logic [63:0] r;
    logic [19:0] pa;
    int kind;
    bit rd, wr, io;

    sram[int'(20'o1234)] = 36'o123456701234;
    ref_mem[int'(20'o1234)] = 36'o123456701234;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_av[cyc] = 1'b1; exp_dv[cyc] = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", cyc, {busACKO, ssramRD, ssramWR, nxmO, 32'd0}, 36'd0);
    chk("reset_addr", cyc, {16'd0, ssramADDR}, 36'd0);
    @(posedge clk); #1;

    // Read with two wait states: ack exactly at cycle 4.
    txn(1'b1, 1'b0, 1'b0, 20'o1234, 36'd0, 4, 2, t0);
    chk("lit_read_ack", t0 + 4, {35'd0, obs_ack[t0+4]}, 36'd1);
    chk("lit_read_noack3", t0 + 3, {35'd0, obs_ack[t0+3]}, 36'd0);
    chk("lit_read_data", t0 + 4, obs_data[t0+4], 36'o123456701234);

    // Write then read back.
    txn(1'b0, 1'b1, 1'b0, 20'o2000, 36'o777777000000, 4, 2, t0);
    chk("lit_wr_strobe", t0 + 1, {35'd0, obs_wr[t0+1]}, 36'd1);
    chk("lit_wr_addr", t0 + 1, {16'd0, obs_addr[t0+1]}, {16'd0, 20'o2000});
    chk("lit_wr_ack", t0 + 4, {35'd0, obs_ack[t0+4]}, 36'd1);
    txn(1'b1, 1'b0, 1'b0, 20'o2000, 36'd0, 5, 1, t0);
    chk("lit_rdback", t0 + 4, obs_data[t0+4], 36'o777777000000);

    // NXM with a long-held request.
    txn(1'b1, 1'b0, 1'b0, 20'o1000000, 36'd0, 20, 1, t0);
    chk("lit_nxm", t0 + 1, {35'd0, obs_nxm[t0+1]}, 36'd1);
    n = 0;
    for (int c = t0; c <= t0 + 20; c++) n += int'(obs_ack[c]);
    chk("lit_nxm_noack", t0, 36'(n), 36'd0);

    // I/O cycle and flagless cycle, then a normal read.
    txn(1'b1, 1'b0, 1'b1, 20'o1234, 36'd0, 3, 1, t0);
    txn(1'b0, 1'b0, 1'b0, 20'o1234, 36'd0, 3, 1, nxt);
    n = 0;
    for (int c = t0; c < nxt + 4; c++) n += int'(obs_rd[c]) + int'(obs_wr[c]) + int'(obs_ack[c]);
    chk("lit_io_quiet", t0, 36'(n), 36'd0);
    txn(1'b1, 1'b0, 1'b0, 20'o1234, 36'd0, 4, 2, t0);
    chk("lit_after_io", t0 + 4, obs_data[t0+4], 36'o123456701234);

    // Held request: one ack, then 1-cycle drop and re-raise.
    txn(1'b1, 1'b0, 1'b0, 20'o1234, 36'd0, 14, 1, t0);
    n = 0;
    for (int c = t0; c < t0 + 15; c++) n += int'(obs_ack[c]);
    chk("lit_hold_one_ack", t0, 36'(n), 36'd1);
    txn(1'b1, 1'b0, 1'b0, 20'o2000, 36'd0, 4, 2, t0);
    chk("lit_rerais_ack", t0 + 4, {35'd0, obs_ack[t0+4]}, 36'd1);

    // Read+write together is a read.
    txn(1'b1, 1'b1, 1'b0, 20'o1234, 36'o1, 4, 2, t0);
    chk("lit_rpw_nowr", t0 + 1, {35'd0, obs_wr[t0+1]}, 36'd0);

    // Drop during WAIT: no ack; next request normal.
    txn(1'b1, 1'b0, 1'b0, 20'o1234, 36'd0, 3, 1, t0);
    chk("lit_drop_noack", t0 + 4, {35'd0, obs_ack[t0+4]}, 36'd0);
    txn(1'b1, 1'b0, 1'b0, 20'o2000, 36'd0, 4, 2, t0);
    chk("lit_after_drop", t0 + 4, obs_data[t0+4], 36'o777777000000);

    // Reset during WAIT.
    sched(1'b1, 1'b0, 1'b0, 20'o1234, 36'd0, 10, 1, t0, nxt);
    for (int c = t0 + 3; c <= t0 + 20; c++) begin
      exp_ack[c] = 1'b0; exp_rd[c] = 1'b0; exp_wr[c] = 1'b0; exp_nxm[c] = 1'b0;
      exp_data[c] = 36'd0; exp_av[c] = 1'b0; exp_dv[c] = 1'b0;
    end
    exp_av[t0+3] = 1'b1; exp_addr[t0+3] = 20'd0;
    exp_dv[t0+3] = 1'b1; exp_dout[t0+3] = 36'd0;
    busREQI = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    busREQI = 1'b0;
    @(posedge clk); #1;
    chk("lit_rst_ack", t0 + 3, {35'd0, obs_ack[t0+3]}, 36'd0);
    chk("lit_rst_addr", t0 + 3, {16'd0, obs_addr[t0+3]}, 36'd0);
    txn(1'b1, 1'b0, 1'b0, 20'o1234, 36'd0, 4, 2, t0);
    chk("lit_after_rst", t0 + 4, obs_data[t0+4], 36'o123456701234);

    // Randomized traffic against the model.
    for (int i = 0; i < 150 && cyc < N - 64; i++) begin
      kind = int'($urandom_range(0, 9));
      rd = (kind <= 3) || (kind == 7) || (kind == 8 && $urandom_range(0, 1) == 1);
      wr = (kind >= 4 && kind <= 7);
      io = (kind == 8);
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: pa = 20'(MW - 1);
          1: pa = 20'(MW);
          default: pa = 20'hFFFFF;
        endcase
      end else begin
        pa = 20'($urandom_range(0, 31));
      end
      r = {$urandom(), $urandom()};
      txn(rd, wr, io, pa, r[35:0], int'($urandom_range(1, 8)), int'($urandom_range(1, 3)), t0);
    end

    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
